// File: rtl/stack_peek_arb.sv
// Shares one stack2 instance between the J1B core and a debug host.
// A peek stalls the core, walks the pointer down to the entry, captures it and walks back.
module stack_peek_arb #(
  parameter int WIDTH = 32,
  parameter int PBITS = 5
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             cpu_we,
  input  logic [1:0]       cpu_delta,
  input  logic [WIDTH-1:0] cpu_wd,
  output logic             cpu_stall,
  output logic             stk_we,
  output logic [1:0]       stk_delta,
  output logic [WIDTH-1:0] stk_wd,
  input  logic [WIDTH-1:0] stk_rd,
  input  logic [PBITS-1:0] stk_depth,
  input  logic             dbg_req,
  input  logic [PBITS-1:0] dbg_idx,
  output logic             dbg_ack,
  output logic             dbg_err,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [2:0] {IDLE, DOWN, CAPT, UP, DONE} state_t;

  localparam logic [PBITS-1:0] CNT_ONE = PBITS'(1);

  state_t           state, state_nx;
  logic [PBITS-1:0] cnt, cnt_nx;
  logic [PBITS-1:0] idx, idx_nx;
  logic             err, err_nx;
  logic [WIDTH-1:0] data_q, data_nx;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      err    <= 1'b0;
      data_q <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      err    <= err_nx;
      data_q <= data_nx;
    end
  end

  // The core command is dropped (not queued) in every stalled cycle; the core re-issues it.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    err_nx    = err;
    data_nx   = data_q;
    cpu_stall = 1'b1;
    stk_we    = 1'b0;
    stk_delta = 2'b00;
    stk_wd    = '0;
    dbg_ack   = 1'b0;
    dbg_err   = 1'b0;

    unique case (state)
      IDLE: begin
        if (dbg_req) begin
          idx_nx = dbg_idx;
          cnt_nx = dbg_idx;
          err_nx = 1'b0;
          if (dbg_idx > stk_depth) begin
            err_nx   = 1'b1;
            data_nx  = '0;
            state_nx = DONE;
          end else if (dbg_idx == '0) begin
            state_nx = CAPT;
          end else begin
            state_nx = DOWN;
          end
        end else begin
          cpu_stall = 1'b0;
          stk_we    = cpu_we;
          stk_delta = cpu_delta;
          stk_wd    = cpu_wd;
        end
      end
      DOWN: begin
        stk_delta = 2'b11;
        cnt_nx    = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nx = CAPT;
      end
      CAPT: begin
        data_nx  = stk_rd;
        cnt_nx   = idx;
        state_nx = (idx == '0) ? DONE : UP;
      end
      // Push without write only re-reads RAM, so the walk back leaves contents untouched.
      UP: begin
        stk_delta = 2'b01;
        cnt_nx    = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nx = DONE;
      end
      DONE: begin
        dbg_ack  = 1'b1;
        dbg_err  = err;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dbg_data = data_q;

endmodule

// File: tb/tb_stack_peek_arb.sv
// Bench for stack_peek_arb: a pointer-based stack2 stand-in plus a queue model of the stack
// contents and the peek timing rules.
module tb_stack_peek_arb;

  logic        clk;
  logic        resetq;
  logic        cpu_we;
  logic [1:0]  cpu_delta;
  logic [31:0] cpu_wd;
  logic        cpu_stall;
  logic        stk_we;
  logic [1:0]  stk_delta;
  logic [31:0] stk_wd;
  logic [31:0] stk_rd;
  logic [4:0]  stk_depth;
  logic        dbg_req;
  logic [4:0]  dbg_idx;
  logic        dbg_ack;
  logic        dbg_err;
  logic [31:0] dbg_data;

  int checks;
  int failures;

  logic [31:0] ref_q[$];

  stack_peek_arb #(.WIDTH(32), .PBITS(5)) dut (
    .clk(clk), .resetq(resetq),
    .cpu_we(cpu_we), .cpu_delta(cpu_delta), .cpu_wd(cpu_wd), .cpu_stall(cpu_stall),
    .stk_we(stk_we), .stk_delta(stk_delta), .stk_wd(stk_wd),
    .stk_rd(stk_rd), .stk_depth(stk_depth),
    .dbg_req(dbg_req), .dbg_idx(dbg_idx),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for stack2: RAM plus pointer, rd holds ram[ptr] after every edge.
  logic [31:0] ram [32];
  logic [4:0]  ptr;
  logic [31:0] rd_q;

  initial for (int i = 0; i < 32; i++) ram[i] = 32'h0;

  always @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      ptr  <= 5'd0;
      rd_q <= 32'h0;
    end else begin
      case (stk_delta)
        2'b01: begin
          ptr <= ptr + 5'd1;
          if (stk_we) begin
            ram[ptr + 5'd1] <= stk_wd;
            rd_q            <= stk_wd;
          end else begin
            rd_q <= ram[ptr + 5'd1];
          end
        end
        2'b11: begin
          ptr  <= ptr - 5'd1;
          rd_q <= ram[ptr - 5'd1];
        end
        default: begin
          if (stk_we) begin
            ram[ptr] <= stk_wd;
            rd_q     <= stk_wd;
          end
        end
      endcase
    end
  end

  assign stk_rd    = rd_q;
  assign stk_depth = ptr;

  task automatic apply_ref(input logic we, input logic [1:0] delta, input logic [31:0] wd);
    if (delta == 2'b01) ref_q.push_back(wd);
    else if (delta == 2'b11) void'(ref_q.pop_back());
    else if (we && ref_q.size() > 0) ref_q[ref_q.size()-1] = wd;
  endtask

  // One unstalled core cycle; entered and left #1 after a rising edge.
  task automatic core_op(input logic we, input logic [1:0] delta, input logic [31:0] wd);
    cpu_we = we; cpu_delta = delta; cpu_wd = wd;
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b0 || stk_we !== we || stk_delta !== delta || stk_wd !== wd) begin
      failures++;
      $display("[TB] FAIL passthrough: stall=%b we=%b delta=%b wd=%h, want stall=0 we=%b delta=%b wd=%h",
               cpu_stall, stk_we, stk_delta, stk_wd, we, delta, wd);
    end
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_delta = 2'b00; cpu_wd = 32'h0;
    apply_ref(we, delta, wd);
    checks++;
    if (stk_depth !== 5'(ref_q.size())) begin
      failures++;
      $display("[TB] FAIL depth_after_op: got %0d want %0d", stk_depth, ref_q.size());
    end
    if (ref_q.size() > 0) begin
      checks++;
      if (stk_rd !== ref_q[ref_q.size()-1]) begin
        failures++;
        $display("[TB] FAIL rd_after_op: got %h want %h", stk_rd, ref_q[ref_q.size()-1]);
      end
    end
  endtask

  task automatic random_core_op();
    int sz;
    int sel;
    sz  = ref_q.size();
    sel = (sz == 0) ? 0 : (sz >= 24) ? 1 : int'($urandom_range(0, 3));
    case (sel)
      0:       core_op(1'b1, 2'b01, $urandom);
      1:       core_op(1'b0, 2'b11, 32'h0);
      2:       core_op(1'b0, 2'b00, 32'h0);
      default: core_op(1'b1, 2'b00, $urandom);
    endcase
  endtask

  // Full peek of entry k, optionally with a core command pending from the accept cycle.
  task automatic do_peek(input int k, input bit use_core, input logic cwe,
                         input logic [1:0] cdelta, input logic [31:0] cwd, input bit hold_req);
    logic [1:0]  exp_seq[$];
    logic [1:0]  seq[$];
    logic [31:0] exp_data;
    int          sz, exp_len, cyc, ack_cyc;
    bit          exp_err, acked, got_err, stall_bad, we_seen, seq_ok, check_data;

    sz         = ref_q.size();
    exp_err    = (k > sz);
    exp_len    = exp_err ? 2 : 2 * k + 3;
    check_data = exp_err || (k < sz);
    exp_data   = exp_err ? 32'h0 : (k < sz ? ref_q[sz-1-k] : 32'h0);
    exp_seq.push_back(2'b00);
    if (!exp_err) begin
      for (int i = 0; i < k; i++) exp_seq.push_back(2'b11);
      exp_seq.push_back(2'b00);
      for (int i = 0; i < k; i++) exp_seq.push_back(2'b01);
    end
    exp_seq.push_back(2'b00);

    dbg_req = 1'b1;
    dbg_idx = 5'(k);
    if (use_core) begin
      cpu_we = cwe; cpu_delta = cdelta; cpu_wd = cwd;
    end
    cyc = 0; ack_cyc = 0; acked = 0; got_err = 0; stall_bad = 0; we_seen = 0;
    while (!acked && cyc < 100) begin
      @(negedge clk);
      cyc++;
      seq.push_back(stk_delta);
      if (stk_we !== 1'b0) we_seen = 1;
      if (cpu_stall !== 1'b1) stall_bad = 1;
      if (dbg_ack === 1'b1) begin
        acked   = 1;
        ack_cyc = cyc;
        got_err = dbg_err;
      end
      @(posedge clk); #1;
      if (acked && !hold_req) dbg_req = 1'b0;
    end

    checks++;
    if (ack_cyc != exp_len) begin
      failures++;
      $display("[TB] FAIL ack_latency k=%0d: ack in cycle %0d, want %0d", k, ack_cyc, exp_len);
    end
    checks++;
    if (got_err !== exp_err) begin
      failures++;
      $display("[TB] FAIL dbg_err k=%0d: got %b want %b", k, got_err, exp_err);
    end
    if (check_data) begin
      checks++;
      if (dbg_data !== exp_data) begin
        failures++;
        $display("[TB] FAIL dbg_data k=%0d: got %h want %h", k, dbg_data, exp_data);
      end
    end
    seq_ok = (seq.size() == exp_seq.size());
    if (seq_ok) foreach (seq[i]) if (seq[i] !== exp_seq[i]) seq_ok = 0;
    checks++;
    if (!seq_ok || stall_bad || we_seen) begin
      failures++;
      $display("[TB] FAIL walk k=%0d: delta seq len %0d (want %0d) stall_drop=%b we_seen=%b",
               k, seq.size(), exp_seq.size(), stall_bad, we_seen);
    end

    if (!hold_req) begin
      @(negedge clk);
      checks++;
      if (cpu_stall !== 1'b0 || (use_core && (stk_we !== cwe || stk_delta !== cdelta))) begin
        failures++;
        $display("[TB] FAIL release k=%0d: stall=%b we=%b delta=%b, want stall=0 core cmd",
                 k, cpu_stall, stk_we, stk_delta);
      end
      @(posedge clk); #1;
      if (use_core) begin
        apply_ref(cwe, cdelta, cwd);
        cpu_we = 1'b0; cpu_delta = 2'b00; cpu_wd = 32'h0;
      end
      checks++;
      if (stk_depth !== 5'(ref_q.size())) begin
        failures++;
        $display("[TB] FAIL depth_after_peek: got %0d want %0d", stk_depth, ref_q.size());
      end
      if (ref_q.size() > 0) begin
        checks++;
        if (stk_rd !== ref_q[ref_q.size()-1]) begin
          failures++;
          $display("[TB] FAIL rd_after_peek: got %h want %h", stk_rd, ref_q[ref_q.size()-1]);
        end
      end
    end
  endtask

  task automatic test_reset();
    resetq = 1'b0;
    cpu_we = 1'b1; cpu_delta = 2'b01; cpu_wd = 32'hA5A5_0001;
    dbg_req = 1'b0; dbg_idx = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || dbg_ack !== 1'b0 || dbg_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: stall=%b ack=%b err=%b, want 0 0 0", cpu_stall, dbg_ack, dbg_err);
    end
    checks++;
    if (dbg_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h want 0", dbg_data);
    end
    checks++;
    if (stk_we !== 1'b1 || stk_delta !== 2'b01 || stk_wd !== 32'hA5A5_0001) begin
      failures++;
      $display("[TB] FAIL reset_passthrough: we=%b delta=%b wd=%h, want 1 01 a5a50001",
               stk_we, stk_delta, stk_wd);
    end
    cpu_we = 1'b0; cpu_delta = 2'b00; cpu_wd = 32'h0;
    @(negedge clk) resetq = 1'b1;
    @(posedge clk); #1;
    ref_q.delete();
    checks++;
    if (stk_depth !== 5'd0) begin
      failures++;
      $display("[TB] FAIL reset_depth: got %0d want 0", stk_depth);
    end
  endtask

  task automatic test_passthrough();
    core_op(1'b1, 2'b01, 32'h11);
    core_op(1'b1, 2'b01, 32'h22);
    core_op(1'b1, 2'b01, 32'h33);
  endtask

  task automatic test_peek_top();
    do_peek(0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic test_peek_deep();
    do_peek(2, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic test_range_error();
    do_peek(5, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic test_contention();
    do_peek(1, 1'b1, 1'b1, 2'b01, 32'h44, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_peek(1, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1);
    do_peek(3, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    int sz;
    for (int n = 0; n < 40; n++) begin
      sz = ref_q.size();
      if ($urandom_range(0, 2) == 0) begin
        random_core_op();
      end else if ($urandom_range(0, 1) == 0 && sz > 0 && sz < 24) begin
        do_peek(int'($urandom_range(0, sz + 2)), 1'b1, 1'b1, 2'b01, $urandom, 1'b0);
      end else begin
        do_peek(int'($urandom_range(0, sz + 2)), 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
      end
    end
  endtask

  task automatic test_async_reset();
    while (ref_q.size() < 3) core_op(1'b1, 2'b01, $urandom);
    dbg_req = 1'b1;
    dbg_idx = 5'd3;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (stk_delta !== 2'b11) begin
      failures++;
      $display("[TB] FAIL async_pre_down: delta=%b want 11", stk_delta);
    end
    #2;
    resetq = 1'b0;
    dbg_req = 1'b0;
    #1;
    checks++;
    if (dbg_ack !== 1'b0 || dbg_err !== 1'b0 || dbg_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL async_outputs: ack=%b err=%b data=%h, want 0 0 0", dbg_ack, dbg_err, dbg_data);
    end
    checks++;
    if (stk_delta !== 2'b00 || cpu_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_idle: delta=%b stall=%b, want 00 0", stk_delta, cpu_stall);
    end
    @(negedge clk) resetq = 1'b1;
    ref_q.delete();
    @(posedge clk); #1;
    checks++;
    if (cpu_stall !== 1'b0 || stk_depth !== 5'd0) begin
      failures++;
      $display("[TB] FAIL async_release: stall=%b depth=%0d, want 0 0", cpu_stall, stk_depth);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    resetq    = 1'b0;
    cpu_we    = 1'b0;
    cpu_delta = 2'b00;
    cpu_wd    = 32'h0;
    dbg_req   = 1'b0;
    dbg_idx   = 5'd0;
    test_reset();
    test_passthrough();
    test_peek_top();
    test_peek_deep();
    test_range_error();
    test_contention();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
